// File: rtl/branch_resolver.sv
// Queues fetch-stage branch predictions and checks the oldest one at Decode,
// raising a registered redirect on a misprediction. Optional stats: BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_WIDTH = 2,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [31:0]          push_pc_i,
    input  logic [31:0]          push_predict_pc_i,
    input  logic                 resolve_i,
    input  logic                 real_taken_i,
    input  logic [31:0]          real_target_i,
    output logic                 redirect_o,
    output logic [31:0]          redirect_pc_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [PTR_WIDTH:0]   count_o,
    output logic [CNT_WIDTH-1:0] hit_cnt_o,
    output logic [CNT_WIDTH-1:0] miss_cnt_o
);

    localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE    = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

    logic [31:0]          pc_mem  [DEPTH];
    logic [31:0]          ppc_mem [DEPTH];
    logic [PTR_WIDTH-1:0] rptr_q;
    logic [PTR_WIDTH-1:0] wptr_q;
    logic [PTR_WIDTH:0]   count_q;
    logic                 redirect_q;
    logic [31:0]          redirect_pc_q;

    logic                 empty;
    logic                 full;
    logic                 pop;
    logic [31:0]          head_pc;
    logic [31:0]          head_ppc;
    logic [31:0]          correct_pc;
    logic                 mispredict;
    logic                 push_ok;

    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_COUNT);
    assign pop        = resolve_i && !empty;
    assign head_pc    = pc_mem[rptr_q];
    assign head_ppc   = ppc_mem[rptr_q];
    assign correct_pc = real_taken_i ? real_target_i : head_pc + 32'd4;
    assign mispredict = pop && (head_ppc != correct_pc);
    // A push that lands in a mispredict or flush cycle is wrong-path and is dropped.
    assign push_ok    = push_i && (!full || pop) && !mispredict && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_q        <= '0;
            wptr_q        <= '0;
            count_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else if (en_i) begin
            if (flush_i) begin
                rptr_q     <= '0;
                wptr_q     <= '0;
                count_q    <= '0;
                redirect_q <= 1'b0;
            end else if (mispredict) begin
                rptr_q        <= '0;
                wptr_q        <= '0;
                count_q       <= '0;
                redirect_q    <= 1'b1;
                redirect_pc_q <= correct_pc;
            end else begin
                redirect_q <= 1'b0;
                if (push_ok) begin
                    wptr_q <= wptr_q + PTR_ONE;
                end
                if (pop) begin
                    rptr_q <= rptr_q + PTR_ONE;
                end
                case ({push_ok, pop})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Entry storage needs no reset: it is only read while count_q is non-zero.
    always_ff @(posedge clk_i) begin
        if (en_i && push_ok) begin
            pc_mem[wptr_q]  <= push_pc_i;
            ppc_mem[wptr_q] <= push_predict_pc_i;
        end
    end

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign full_o        = full;
    assign empty_o       = empty;
    assign count_o       = count_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    localparam logic [CNT_WIDTH-1:0] STAT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] hit_q;
    logic [CNT_WIDTH-1:0] miss_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (en_i && !flush_i && pop) begin
            if (mispredict) begin
                if (miss_q != '1) begin
                    miss_q <= miss_q + STAT_ONE;
                end
            end else if (hit_q != '1) begin
                hit_q <= hit_q + STAT_ONE;
            end
        end
    end

    assign hit_cnt_o  = hit_q;
    assign miss_cnt_o = miss_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a queue-based reference model predicts each
// cycle's outputs; a monitor process pops and compares them after every clock edge.
module tb_branch_resolver;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_i;
    logic        en_i;
    logic        flush_i;
    logic        push_i;
    logic [31:0] push_pc_i;
    logic [31:0] push_predict_pc_i;
    logic        resolve_i;
    logic        real_taken_i;
    logic [31:0] real_target_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        full_o;
    logic        empty_o;
    logic [2:0]  count_o;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    branch_resolver dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .en_i              (en_i),
        .flush_i           (flush_i),
        .push_i            (push_i),
        .push_pc_i         (push_pc_i),
        .push_predict_pc_i (push_predict_pc_i),
        .resolve_i         (resolve_i),
        .real_taken_i      (real_taken_i),
        .real_target_i     (real_target_i),
        .redirect_o        (redirect_o),
        .redirect_pc_o     (redirect_pc_o),
        .full_o            (full_o),
        .empty_o           (empty_o),
        .count_o           (count_o),
        .hit_cnt_o         (hit_cnt_o),
        .miss_cnt_o        (miss_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ppc;
    } ent_t;

    typedef struct {
        logic        red;
        logic [31:0] rpc;
        int          cnt;
        logic [31:0] hit;
        logic [31:0] miss;
    } exp_t;

    ent_t        mq[$];
    exp_t        exp_q[$];
    logic        m_red;
    logic [31:0] m_rpc;
    logic [31:0] m_hit;
    logic [31:0] m_miss;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_red  = 1'b0;
        m_rpc  = '0;
        m_hit  = '0;
        m_miss = '0;
    endtask

    task automatic model_step(input logic en, input logic fl, input logic pu,
                              input logic [31:0] pc, input logic [31:0] ppc,
                              input logic rs, input logic tk, input logic [31:0] tg);
        ent_t        e;
        logic [31:0] corr;
        logic        mis;
        if (!en) return;
        if (fl) begin
            mq.delete();
            m_red = 1'b0;
            return;
        end
        mis   = 1'b0;
        m_red = 1'b0;
        if (rs && mq.size() > 0) begin
            e    = mq.pop_front();
            corr = tk ? tg : e.pc + 32'd4;
            if (e.ppc != corr) begin
                mis   = 1'b1;
                mq.delete();
                m_red = 1'b1;
                m_rpc = corr;
`ifdef BRANCH_RESOLVER_STATS_EN
                if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
`endif
            end else begin
`ifdef BRANCH_RESOLVER_STATS_EN
                if (m_hit != 32'hFFFF_FFFF) m_hit = m_hit + 1;
`endif
            end
        end
        if (pu && !mis && mq.size() < DEPTH) mq.push_back('{pc: pc, ppc: ppc});
    endtask

    function automatic exp_t snapshot();
        exp_t x;
        x.red  = m_red;
        x.rpc  = m_rpc;
        x.cnt  = mq.size();
        x.hit  = m_hit;
        x.miss = m_miss;
        return x;
    endfunction

    task automatic drive(input logic en, input logic fl, input logic pu,
                         input logic [31:0] pc, input logic [31:0] ppc,
                         input logic rs, input logic tk, input logic [31:0] tg);
        @(negedge clk);
        en_i              = en;
        flush_i           = fl;
        push_i            = pu;
        push_pc_i         = pc;
        push_predict_pc_i = ppc;
        resolve_i         = rs;
        real_taken_i      = tk;
        real_target_i     = tg;
        model_step(en, fl, pu, pc, ppc, rs, tk, tg);
        exp_q.push_back(snapshot());
        @(posedge clk);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_redirect"}, {31'b0, redirect_o}, 32'h0);
        chk({tag, "_redirect_pc"}, redirect_pc_o, 32'h0);
        chk({tag, "_count"}, {29'b0, count_o}, 32'h0);
        chk({tag, "_empty"}, {31'b0, empty_o}, 32'h1);
        chk({tag, "_full"}, {31'b0, full_o}, 32'h0);
        chk({tag, "_hit"}, hit_cnt_o, 32'h0);
        chk({tag, "_miss"}, miss_cnt_o, 32'h0);
    endtask

    // Asserts reset between edges, checks the asynchronous effect, then holds it one edge.
    task automatic mid_reset();
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        en_i      = 1'b1;
        push_i    = 1'b0;
        resolve_i = 1'b0;
        flush_i   = 1'b0;
        model_reset();
        exp_q.push_back(snapshot());
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // Monitor: compares the scoreboard entry for every edge that had stimulus.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("redirect", {31'b0, redirect_o}, {31'b0, x.red});
                chk("redirect_pc", redirect_pc_o, x.rpc);
                chk("count", {29'b0, count_o}, x.cnt);
                chk("empty", {31'b0, empty_o}, {31'b0, (x.cnt == 0)});
                chk("full", {31'b0, full_o}, {31'b0, (x.cnt == DEPTH)});
                chk("hit_cnt", hit_cnt_o, x.hit);
                chk("miss_cnt", miss_cnt_o, x.miss);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] ppc;
        logic        tk;
        logic [31:0] tg;
        logic        rs;
        int          drain;

        rst_i             = 1'b1;
        en_i              = 1'b0;
        flush_i           = 1'b0;
        push_i            = 1'b0;
        push_pc_i         = '0;
        push_predict_pc_i = '0;
        resolve_i         = 1'b0;
        real_taken_i      = 1'b0;
        real_target_i     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_i = 1'b0;

        // Correct not-taken prediction.
        drive(1, 0, 1, 32'h100, 32'h104, 0, 0, 32'h0);
        drive(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
        idle();

        // Taken branch predicted fall-through -> redirect to 0x300 for one cycle.
        drive(1, 0, 1, 32'h200, 32'h204, 0, 0, 32'h0);
        drive(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h300);
        idle();
        idle();

        // Fill, drop a push while full, then push+pop together.
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 1, 32'h400 + 32'(i * 16), 32'h404 + 32'(i * 16), 0, 0, 0);
        drive(1, 0, 1, 32'h500, 32'h504, 0, 0, 32'h0);
        drive(1, 0, 1, 32'h600, 32'h604, 1, 0, 32'h0);
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, 0, 0, 1, 0, 0);

        // Mispredict with a same-cycle push: the push is wrong-path.
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 32'h700 + 32'(i * 8), 32'h704 + 32'(i * 8), 0, 0, 0);
        drive(1, 0, 1, 32'h800, 32'h804, 1, 1, 32'h900);
        idle();

        // Flush beats a mispredicting resolve.
        drive(1, 0, 1, 32'hA00, 32'hA04, 0, 0, 32'h0);
        drive(1, 0, 1, 32'hA10, 32'hA14, 0, 0, 32'h0);
        drive(1, 1, 1, 32'hB00, 32'hB04, 1, 1, 32'hC00);
        idle();

        // en low holds a pending redirect and the queue.
        drive(1, 0, 1, 32'hD00, 32'hDEAD_0000, 0, 0, 32'h0);
        drive(1, 0, 1, 32'hD10, 32'hD14, 1, 0, 32'h0);
        drive(0, 0, 1, 32'hE00, 32'hE04, 1, 0, 32'h0);
        drive(0, 1, 0, 32'h0, 32'h0, 1, 0, 32'h0);
        idle();

        // 32-bit wrap of pc+4.
        drive(1, 0, 1, 32'hFFFF_FFFC, 32'h0, 0, 0, 32'h0);
        drive(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0);

        // Mispredict, then reset before the next edge.
        drive(1, 0, 1, 32'hF00, 32'hF04, 0, 0, 32'h0);
        drive(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h1234);
        mid_reset();

        // Randomized traffic, biased so most resolves hit a non-empty queue.
        for (int n = 0; n < 3000; n++) begin
            pc  = {$urandom(), 2'b00} >> 0;
            pc  = {pc[31:2], 2'b00};
            if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
            ppc = ($urandom_range(0, 1) == 1) ? pc + 32'd4 : {$urandom_range(0, 255), 2'b00};
            rs  = ($urandom_range(0, 99) < 45);
            tk  = $urandom_range(0, 1);
            tg  = {$urandom_range(0, 255), 2'b00};
            if (mq.size() > 0 && $urandom_range(0, 99) < 65) begin
                if (mq[0].ppc == mq[0].pc + 32'd4) begin
                    tk = 1'b0;
                end else begin
                    tk = 1'b1;
                    tg = mq[0].ppc;
                end
            end
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 99) < 55, pc, ppc, rs, tk, tg);
            if ($urandom_range(0, 499) == 0) mid_reset();
        end

        drain = 0;
        while (exp_q.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumer end of the fetch-stage branch prediction interface.
- Queues each prediction issued at Fetch: branch PC and predicted next PC.
- At Decode it compares the oldest queued prediction against the resolved outcome. On a wrong guess it raises a registered one-cycle redirect with the correct PC and discards all younger (wrong-path) predictions.

Parameters:
- DEPTH, 4: number of in-flight prediction entries; power of two, at least 2.
- PTR_WIDTH, 2: log2(DEPTH).
- CNT_WIDTH, 32: width of the statistics counters (optional feature only).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- en_i  input  1  pipeline enable; when low, every register holds its value.
- flush_i  input  1  external flush (exception/eret); empties the queue.
- push_i  input  1  a prediction was issued at Fetch this cycle.
- push_pc_i  input  32  PC of the predicted branch.
- push_predict_pc_i  input  32  next PC chosen by the predictor.
- resolve_i  input  1  Decode resolves the oldest queued branch this cycle.
- real_taken_i  input  1  resolved direction.
- real_target_i  input  32  resolved taken-target.
- redirect_o  output  1  registered misprediction pulse.
- redirect_pc_o  output  32  correct next PC; valid while redirect_o is high.
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.
- count_o  output  PTR_WIDTH+1  number of valid entries.
- hit_cnt_o  output  CNT_WIDTH  correct predictions (optional feature only).
- miss_cnt_o  output  CNT_WIDTH  mispredictions (optional feature only).

Behaviour:
- Reset: queue empty, read and write pointers 0, count_o=0, empty_o=1, full_o=0, redirect_o=0, redirect_pc_o=0, counters 0.
- en_i low: no push, no pop, no counter update. redirect_o and redirect_pc_o hold.
- Storage: circular FIFO of {pc, predict_pc}. Pointers wrap modulo DEPTH; wrap is handled by the pointer arithmetic.
- Accepted push: push_i && !full_o, or push_i && full_o && pop this cycle. The entry is written at wptr and wptr increments.
- Push while full with no pop: silently dropped; state unchanged.
- Pop: resolve_i && !empty_o. The oldest entry is compared, then rptr increments.
- Resolve while empty: ignored; no redirect, no counter change.
- Correct PC: real_taken_i ? real_target_i : entry.pc + 32'd4. Addition is 32-bit, wrapping.
- Mispredict: entry.predict_pc != correct PC.
- Latency: redirect_o=1 and redirect_pc_o=correct PC on the edge after the resolving cycle (1 cycle).
- redirect_o returns to 0 on the next enabled edge unless another mispredict occurs. redirect_pc_o holds its last value when redirect_o=0.
- On mispredict, at the same edge: queue cleared (rptr=wptr=0, count=0). Any push in that cycle is dropped as wrong-path.
- Correct resolve: pop only; redirect_o=0 next cycle.
- Simultaneous push and pop, no mispredict: count unchanged, both pointers advance.
- flush_i has highest priority, same edge:
  - Queue cleared, push dropped, resolve ignored.
  - redirect_o=0 next cycle; counters not updated.
- Reset mid-operation: immediate asynchronous return to the reset state, including a redirect_o in flight.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- Defined:
  - hit_cnt_o increments on each correct pop; miss_cnt_o increments on each mispredicting pop.
  - Both saturate at all-ones. Neither changes on flush_i or when en_i is low.
- Undefined:
  - Both ports still exist and are tied to 0.
  - No counter registers are synthesised.

Test Plan:
- Reset then push pc=0x100, predict=0x104; resolve not-taken -> redirect_o stays 0; count_o 1 -> 0; hit_cnt_o=1 (macro on).
- Push pc=0x200, predict=0x204; resolve taken, target=0x300 -> next cycle redirect_o=1, redirect_pc_o=0x300; one cycle later redirect_o=0; miss_cnt_o=1.
- Push 4 entries (full_o=1); 5th push alone -> dropped, count_o=4. Then push + correct resolve in the same cycle -> count_o stays 4, pointers wrap to 1.
- 3 entries queued; mispredicting resolve of oldest plus push in the same cycle -> count_o=0, empty_o=1, redirect_o=1 next cycle.
- 2 entries queued; flush_i with resolve_i (mispredicting data) -> queue empty, redirect_o=0, counters unchanged.
- Mispredict resolve, then rst_i asserted mid-cycle before the next edge -> redirect_o=0 immediately, all outputs at reset values.
